gait_sequencer: RTL

Sequences the six leg-joint servo channels through a stored gait. Supported gaits are stand, forward, turn-left and turn-right. The block sits between the command inputs (keys, switches or a host) and the six per-joint speed-ramp instances. For each pose it issues one 6-angle target, waits until every joint reports done, dwells for a programmable time, then advances. Gait changes are taken only at pose boundaries, so a stride is never torn mid-pose.

---
 rtl/gait_pkg.sv | 76 +++++++
 rtl/gait_pose_rom.sv | 25 ++
 rtl/gait_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/gait_pkg.sv
// gait_pkg: shared encodings and pose tables for the gait sequencer.
// Holds the gait mode encoding, FSM state encoding, per-gait pose counts,
// the neutral angle and the 6-lane pose constants (lane order, LSB first:
// l1, l2, l3, r1, r2, r3; 8 bits per lane, degrees).
package gait_pkg;

  localparam int unsigned NUM_JOINTS = 6;
  localparam int unsigned ANGLE_W    = 8;
  localparam int unsigned POSE_W     = NUM_JOINTS * ANGLE_W;
  localparam int unsigned IDX_W      = 3;

  typedef logic [POSE_W-1:0] pose_t;

  typedef enum logic [1:0] {
    MODE_STAND   = 2'd0,
    MODE_FORWARD = 2'd1,
    MODE_LEFT    = 2'd2,
    MODE_RIGHT   = 2'd3
  } gait_mode_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_BLANK     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DWELL     = 3'd4
  } gait_state_e;

  localparam logic [ANGLE_W-1:0] ANGLE_NEUTRAL = 8'd90;
  localparam pose_t POSE_NEUTRAL = {NUM_JOINTS{ANGLE_NEUTRAL}};

  // Tables are padded to 8 entries with the neutral pose so any 3-bit index is safe.
  localparam pose_t FWD_POSES [8] = '{
    48'h5A5A3C5A5A3C,  // l1 60, r1 60
    48'h6E5A3C5A6E3C,  // l1 60, l2 110, r1 60, r3 110
    48'h6E5A785A6E78,  // l1 120, l2 110, r1 120, r3 110
    48'h5A5A785A5A78,  // l1 120, r1 120
    48'h5A6E786E5A78,  // l1 120, l3 110, r1 120, r2 110
    48'h5A6E3C6E5A3C,  // l1 60, l3 110, r1 60, r2 110
    POSE_NEUTRAL,
    POSE_NEUTRAL
  };

  localparam pose_t LEFT_POSES [8] = '{
    48'h5A5A785A5A78,  // l1 120, r1 120
    48'h6E5A785A6E3C,  // l1 60, l2 110, r1 120, r3 110
    48'h5A5A785A5A3C,  // l1 60, r1 120
    POSE_NEUTRAL,
    POSE_NEUTRAL,
    POSE_NEUTRAL,
    POSE_NEUTRAL,
    POSE_NEUTRAL
  };

  localparam pose_t RIGHT_POSES [8] = '{
    48'h5A5A3C5A5A3C,  // l1 60, r1 60
    48'h6E5A3C5A6E78,  // l1 120, l2 110, r1 60, r3 110
    48'h5A5A3C5A5A78,  // l1 120, r1 60
    POSE_NEUTRAL,
    POSE_NEUTRAL,
    POSE_NEUTRAL,
    POSE_NEUTRAL,
    POSE_NEUTRAL
  };

  // Number of poses in each gait.
  function automatic logic [IDX_W-1:0] gait_len(input gait_mode_e mode);
    case (mode)
      MODE_FORWARD: gait_len = 3'd6;
      MODE_LEFT:    gait_len = 3'd4;
      MODE_RIGHT:   gait_len = 3'd4;
      default:      gait_len = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/gait_pose_rom.sv
// gait_pose_rom: combinational (mode, pose index) -> 48-bit angle vector.
// Ports:
//   mode_i     in  2  gait mode (gait_mode_e encoding)
//   pose_i     in  3  pose index within the gait
//   angle_c_o  out 48 packed target angles, l1 in [7:0] .. r3 in [47:40]
module gait_pose_rom
  import gait_pkg::*;
(
  input  logic [1:0]  mode_i,
  input  logic [2:0]  pose_i,
  output logic [47:0] angle_c_o
);

  // Pure table lookup; the sequencer registers the result.
  always_comb begin
    angle_c_o = POSE_NEUTRAL;
    case (gait_mode_e'(mode_i))
      MODE_FORWARD: angle_c_o = FWD_POSES[pose_i];
      MODE_LEFT:    angle_c_o = LEFT_POSES[pose_i];
      MODE_RIGHT:   angle_c_o = RIGHT_POSES[pose_i];
      default:      angle_c_o = POSE_NEUTRAL;
    endcase
  end

endmodule

// File: rtl/gait_sequencer.sv
// gait_sequencer: steps six leg-joint servos through a stored gait.
// Each pose: issue a 6-angle target, mask done flags for BLANK_CYCLES,
// wait for all joints done, dwell DWELL_CYCLES, then advance. Gait changes
// are applied only at the dwell->issue boundary.
// Optional build macro GAIT_TIMEOUT_EN adds a WAIT_DONE watchdog with a
// sticky oFault that forces a final STAND pose and then IDLE.
// Ports:
//   iClk        in  1  clock
//   iRst        in  1  synchronous active-high reset
//   iMode       in  2  requested gait (0 STAND, 1 FORWARD, 2 LEFT, 3 RIGHT)
//   iModeValid  in  1  strobe qualifying iMode
//   iPause      in  1  holds the block in DWELL while high
//   iJointDone  in  6  per-joint done flags (bit 0 = l1 .. bit 5 = r3)
//   oAngle      out 48 registered target angles
//   oAngleValid out 1  one-cycle pulse when oAngle updates
//   oMode       out 2  executing gait
//   oPoseIdx    out 3  current pose index
//   oBusy       out 1  high outside IDLE
//   oFault      out 1  sticky watchdog fault (0 without GAIT_TIMEOUT_EN)
module gait_sequencer
  import gait_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES   = 50000,
  parameter int unsigned BLANK_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [1:0]  iMode,
  input  logic        iModeValid,
  input  logic        iPause,
  input  logic [5:0]  iJointDone,
  output logic [47:0] oAngle,
  output logic        oAngleValid,
  output logic [1:0]  oMode,
  output logic [2:0]  oPoseIdx,
  output logic        oBusy,
  output logic        oFault
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned WD_W    = 27;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  gait_state_e       state_q;
  gait_mode_e        mode_q;
  logic [2:0]        idx_q;
  logic [47:0]       angle_q;
  logic              valid_q;
  logic              busy_q;
  logic              pend_v_q;
  gait_mode_e        pend_mode_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              pend_v_d;
  gait_mode_e        pend_mode_d;
  logic              req_take;
  logic              faulted;
  logic [2:0]        pose_next;
  logic [47:0]       rom_angle;

`ifdef GAIT_TIMEOUT_EN
  logic              fault_q;
  logic [WD_W-1:0]   wd_q;
  assign faulted = fault_q;
`else
  // Watchdog limit has no consumer when the watchdog is compiled out.
  logic unused_wd_limit;
  assign unused_wd_limit = ^WD_LIMIT;
  assign faulted = 1'b0;
`endif

  gait_pose_rom u_rom (
    .mode_i    (mode_q),
    .pose_i    (idx_q),
    .angle_c_o (rom_angle)
  );

  // Requests while running go to the pending slot; a repeat of the running
  // gait is dropped only when nothing else is already pending.
  assign req_take    = iModeValid && !faulted && (state_q != S_IDLE) &&
                       (pend_v_q || (gait_mode_e'(iMode) != mode_q));
  assign pend_v_d    = pend_v_q | req_take;
  assign pend_mode_d = req_take ? gait_mode_e'(iMode) : pend_mode_q;

  assign pose_next = (idx_q == gait_len(mode_q) - 3'd1) ? 3'd0 : idx_q + 3'd1;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_STAND;
      idx_q       <= '0;
      angle_q     <= POSE_NEUTRAL;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_mode_q <= MODE_STAND;
      cnt_q       <= '0;
`ifdef GAIT_TIMEOUT_EN
      fault_q     <= 1'b0;
      wd_q        <= '0;
`endif
    end else begin
      valid_q     <= 1'b0;
      pend_v_q    <= pend_v_d;
      pend_mode_q <= pend_mode_d;
      case (state_q)
        S_IDLE: begin
          if (iModeValid && !faulted) begin
            mode_q  <= gait_mode_e'(iMode);
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          angle_q <= rom_angle;
          valid_q <= 1'b1;
          cnt_q   <= '0;
`ifdef GAIT_TIMEOUT_EN
          wd_q    <= '0;
`endif
          state_q <= S_BLANK;
        end
        S_BLANK: begin
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_q <= S_WAIT_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (&iJointDone) begin
            cnt_q   <= '0;
            state_q <= S_DWELL;
          end
`ifdef GAIT_TIMEOUT_EN
          // On timeout drop any pending gait and park via one STAND pose;
          // a second timeout during that pose goes straight to IDLE.
          else if (wd_q == WD_LIMIT) begin
            fault_q  <= 1'b1;
            pend_v_q <= 1'b0;
            mode_q   <= MODE_STAND;
            idx_q    <= '0;
            if (fault_q) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_ISSUE;
            end
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
`endif
        end
        S_DWELL: begin
          // Count saturates at the limit; iPause holds the exit.
          if (cnt_q != CNT_W'(DWELL_CYCLES - 1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else if (!iPause) begin
            if (pend_v_d) begin
              mode_q   <= pend_mode_d;
              idx_q    <= '0;
              pend_v_q <= 1'b0;
              state_q  <= S_ISSUE;
            end else if (mode_q == MODE_STAND) begin
              idx_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              idx_q   <= pose_next;
              state_q <= S_ISSUE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oAngle      = angle_q;
  assign oAngleValid = valid_q;
  assign oMode       = mode_q;
  assign oPoseIdx    = idx_q;
  assign oBusy       = busy_q;
  assign oFault      = faulted;

endmodule
